// File: rtl/data_tx33_if.sv
// ---------------------------------------------------------------------------
// data_tx33_if -- handshake/bus bundle for the data_tx33 burst transmitter.
//
// Parameter
//   DW          data word width in bits
//
// Signals
//   start       burst request (sampled by the transmitter only while idle)
//   seed        first word of the burst, captured with an accepted start
//   stall       downstream hold; suppresses emission for that cycle
//   data        transmitted word
//   data_valid  qualifier for data, one word per high cycle
//   tx_cnt      words emitted so far in the current burst
//   busy        transmitter is not idle
//   done        one-cycle pulse after the last word of a burst
//   data_par    even-parity bit of data (constant 0 unless parity is built in)
//
// Modports
//   master      the side that requests bursts and consumes words
//   slave       the transmitter itself
// ---------------------------------------------------------------------------
interface data_tx33_if #(
  parameter int DW = 8
);
  logic          start;
  logic [DW-1:0] seed;
  logic          stall;
  logic [DW-1:0] data;
  logic          data_valid;
  logic [5:0]    tx_cnt;
  logic          busy;
  logic          done;
  logic          data_par;

  modport master (
    output start, seed, stall,
    input  data, data_valid, tx_cnt, busy, done, data_par
  );

  modport slave (
    input  start, seed, stall,
    output data, data_valid, tx_cnt, busy, done, data_par
  );
endinterface

// File: rtl/data_tx33.sv
// ---------------------------------------------------------------------------
// data_tx33 -- fixed-length burst transmitter.
//
// On an accepted start the seed is captured and NWORDS words are emitted,
// word i being seed+i (modulo 2^DW). A stall holds the burst for a cycle
// without emitting. After the last word a single done pulse is produced and
// the block returns to idle. Starts and seed changes while busy are ignored.
//
// Parameters
//   DW       data word width in bits (default 8)
//   NWORDS   words per burst, 1..63 (default 33)
//
// Ports
//   clk      sole clock, rising edge
//   rst      synchronous, active-high reset
//   bus      data_tx33_if.slave: start/seed/stall in; data, data_valid,
//            tx_cnt, busy, done, data_par out (all outputs registered)
//
// Build option
//   TX_PARITY_EN  when defined, data_par is the registered even parity of
//                 data; when undefined, data_par is tied low and no parity
//                 logic exists.
// ---------------------------------------------------------------------------
module data_tx33 #(
  parameter int DW     = 8,
  parameter int NWORDS = 33
) (
  input  logic         clk,
  input  logic         rst,
  data_tx33_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sum width large enough for both operands so the wrap is taken at DW bits.
  localparam int         SW = (DW > 6) ? DW : 6;
  localparam logic [5:0] NW = 6'(NWORDS);

  state_t        state_q;
  logic [DW-1:0] seed_q;
  logic [DW-1:0] data_q;
  logic          data_valid_q;
  logic [5:0]    tx_cnt_q;
  logic          busy_q;
  logic          done_q;
`ifdef TX_PARITY_EN
  logic          par_q;
`endif

  logic [DW-1:0] word_d;
  logic [5:0]    cnt_d;

  function automatic logic [DW-1:0] word_at(input logic [DW-1:0] s,
                                            input logic [5:0]    c);
    logic [SW-1:0] sum;
    sum = SW'(s) + SW'(c);
    return sum[DW-1:0];
  endfunction

`ifdef TX_PARITY_EN
  function automatic logic even_par(input logic [DW-1:0] w);
    return ^w;
  endfunction
`endif

  always_comb begin
    word_d = word_at(seed_q, tx_cnt_q);
    cnt_d  = tx_cnt_q + 6'd1;
  end

  // DONE lasts two cycles: the first shows the last word (entered on the
  // emitting edge), the second carries the done pulse; done_q tells them apart.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      seed_q       <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      tx_cnt_q     <= 6'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          data_valid_q <= 1'b0;
          done_q       <= 1'b0;
          if (bus.start) begin
            seed_q   <= bus.seed;
            tx_cnt_q <= 6'd0;
            busy_q   <= 1'b1;
            state_q  <= SEND;
          end
        end

        SEND: begin
          if (bus.stall || (tx_cnt_q >= NW)) begin
            data_valid_q <= 1'b0;
          end else begin
            data_q       <= word_d;
            data_valid_q <= 1'b1;
            tx_cnt_q     <= cnt_d;
`ifdef TX_PARITY_EN
            par_q        <= even_par(word_d);
`endif
            if (cnt_d == NW) begin
              state_q <= DONE;
            end
          end
        end

        DONE: begin
          data_valid_q <= 1'b0;
          if (!done_q) begin
            done_q <= 1'b1;
          end else begin
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q      <= IDLE;
          data_valid_q <= 1'b0;
          done_q       <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = data_valid_q;
  assign bus.tx_cnt     = tx_cnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
`ifdef TX_PARITY_EN
  assign bus.data_par   = par_q;
`else
  assign bus.data_par   = 1'b0;
`endif

endmodule

// File: tb/tb_data_tx33.sv
// ---------------------------------------------------------------------------
// tb_data_tx33 -- scoreboard bench for data_tx33 (DW=8, NWORDS=33).
// The stimulus process issues bursts and pushes the words the burst must
// produce (seed+i, count i+1) into a queue; the monitor pops one entry per
// valid word and compares data, tx_cnt and parity, and checks each done pulse.
// ---------------------------------------------------------------------------
module tb_data_tx33;

  localparam int DW     = 8;
  localparam int NWORDS = 33;

  typedef struct packed {
    logic [DW-1:0] w;
    logic [5:0]    c;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];
  logic prev_done;

  data_tx33_if #(.DW(DW)) bus();

  data_tx33 #(.DW(DW), .NWORDS(NWORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_par(input logic [DW-1:0] w);
`ifdef TX_PARITY_EN
    return ^w;
`else
    return (w == w) ? 1'b0 : 1'b1;
`endif
  endfunction

  // Monitor: decoupled from stimulus, samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got data %0h tx_cnt %0d, required no valid word", bus.data, bus.tx_cnt);
      end else begin
        e = sb_q.pop_front();
        check("word_data", 32'(bus.data), 32'(e.w));
        check("word_tx_cnt", 32'(bus.tx_cnt), 32'(e.c));
        check("word_parity", 32'(bus.data_par), 32'(exp_par(e.w)));
      end
    end
    if (bus.done === 1'b1) begin
      check("done_no_valid", 32'(bus.data_valid), 32'd0);
      check("done_busy", 32'(bus.busy), 32'd1);
      check("done_tx_cnt", 32'(bus.tx_cnt), 32'(NWORDS));
      check("done_all_words_seen", 32'(sb_q.size()), 32'd0);
    end
    if (prev_done === 1'b1) begin
      check("done_single_cycle", 32'(bus.done), 32'd0);
    end
    prev_done = bus.done;
  end

  // Waits for idle, then requests a burst; returns #1 after the accepting edge.
  task automatic issue_start(input logic [DW-1:0] s);
    int k;
    k = 0;
    while (bus.busy !== 1'b0 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy still %0b, required 0", bus.busy);
    end
    bus.stall = 1'b0;
    bus.start = 1'b1;
    bus.seed  = s;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < NWORDS; i++) begin
      sb_q.push_back('{w: 8'(s + 8'(i)), c: 6'(i + 1)});
    end
  endtask

  // mode 0: clean burst, 1: 3-cycle stall after word 5, 2: start re-pulsed
  // at word 10, 3: reset at word 20, 4: random stalls.
  task automatic run_burst(input logic [DW-1:0] s, input int mode);
    int n;
    bit seen_done;
    bit acted;
    issue_start(s);
    n = 0;
    seen_done = 0;
    acted = 0;
    while (n < 400) begin
      bus.stall = (mode == 4) ? ($urandom_range(0, 2) == 0) : 1'b0;
      bus.seed  = 8'($urandom);
      @(posedge clk); #1;
      n++;
      if (n == 1 && mode != 4) begin
        check("latency_first_valid", 32'(bus.data_valid), 32'd1);
        check("latency_first_data", 32'(bus.data), 32'(s));
      end
      if (bus.done === 1'b1) begin
        seen_done = 1;
        break;
      end
      if (mode == 1 && !acted && bus.tx_cnt == 6'd5) begin
        acted = 1;
        for (int k = 0; k < 3; k++) begin
          bus.stall = 1'b1;
          @(posedge clk); #1;
          n++;
          check("stall_valid_low", 32'(bus.data_valid), 32'd0);
          check("stall_tx_cnt_held", 32'(bus.tx_cnt), 32'd5);
          check("stall_data_held", 32'(bus.data), 32'(8'(s + 8'd4)));
        end
        bus.stall = 1'b0;
      end
      if (mode == 2 && !acted && bus.tx_cnt == 6'd10) begin
        acted = 1;
        bus.start = 1'b1;
        bus.seed  = ~s;
        @(posedge clk); #1;
        n++;
        bus.start = 1'b0;
      end
      if (mode == 3 && bus.tx_cnt == 6'd20) begin
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        sb_q.delete();
        check("rst_mid_data", 32'(bus.data), 32'd0);
        check("rst_mid_valid", 32'(bus.data_valid), 32'd0);
        check("rst_mid_tx_cnt", 32'(bus.tx_cnt), 32'd0);
        check("rst_mid_busy", 32'(bus.busy), 32'd0);
        check("rst_mid_done", 32'(bus.done), 32'd0);
        check("rst_mid_par", 32'(bus.data_par), 32'd0);
        @(posedge clk); #1;
        check("rst_start_ignored_busy", 32'(bus.busy), 32'd0);
        check("rst_no_valid_after", 32'(bus.data_valid), 32'd0);
        return;
      end
    end
    bus.stall = 1'b0;
    if (!seen_done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done pulse after %0d cycles", n);
      return;
    end
    if (mode == 0 || mode == 2) check("burst_cycles_no_stall", 32'(n), 32'(NWORDS + 1));
    if (mode == 1)              check("burst_cycles_3_stalls", 32'(n), 32'(NWORDS + 4));
    @(posedge clk); #1;
    check("post_done_busy", 32'(bus.busy), 32'd0);
    check("post_done_done", 32'(bus.done), 32'd0);
    check("post_done_valid", 32'(bus.data_valid), 32'd0);
    check("post_done_tx_cnt_held", 32'(bus.tx_cnt), 32'(NWORDS));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    prev_done = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.seed  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", 32'(bus.data), 32'd0);
    check("reset_valid", 32'(bus.data_valid), 32'd0);
    check("reset_tx_cnt", 32'(bus.tx_cnt), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_par", 32'(bus.data_par), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_burst(8'h10, 0);
    run_burst(8'hF0, 0);
    run_burst(8'($urandom), 1);
    run_burst(8'($urandom), 2);
    run_burst(8'($urandom), 3);
    run_burst(8'($urandom), 0);
    run_burst(8'h07, 0);
    run_burst(8'h03, 0);
    for (int b = 0; b < 4; b++) begin
      run_burst(8'($urandom), 4);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
